alu_seq: RTL and testbench

- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Keeps the existing ALU_Control encodings for AND/OR/ADD/SUB/SLT/NOR.
- Adds iterative unsigned multiply/divide into HI/LO registers, plus MFHI/MFLO.
- Sits in the EX stage; stalls the pipeline through the valid/ready handshakes while a multi-cycle op runs.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_muldiv_iter.sv | 98 +++++++++
 rtl/alu_seq.sv | 167 ++++++++++++++++
 tb/tb_alu_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: ALU_Control encodings and sequencer state type, shared by the
// EX-stage ALU and the control unit.
package alu_seq_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;
  localparam logic [3:0] ALU_MFHI  = 4'b1010;
  localparam logic [3:0] ALU_MFLO  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MULTU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier / restoring
// divider. start_i loads operands; done_o flags the final iteration cycle.
module alu_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             run_q, run_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ph_q, ph_d;   // product high / partial remainder
  logic [WIDTH-1:0] pl_q, pl_d;   // multiplier bits / dividend-quotient shifter
  logic [WIDTH-1:0] opb_q, opb_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  // One iteration of either algorithm; on done these are the final HI/LO.
  // A zero divisor makes every trial succeed, which leaves the dividend in
  // the remainder and all ones in the quotient.
  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    mul_sum   = {1'b0, ph_q} + (pl_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {ph_q, pl_q[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    div_ge    = (div_shift >= {1'b0, opb_q});
    step_hi   = mul_sum[WIDTH:1];
    step_lo   = {mul_sum[0], pl_q[WIDTH-1:1]};
    if (div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {pl_q[WIDTH-2:0], div_ge};
    end
  end

  assign done_o = run_q && (cnt_q == LAST);
  assign hi_o   = step_hi;
  assign lo_o   = step_lo;

  always_comb begin
    run_d = run_q;
    div_d = div_q;
    cnt_d = cnt_q;
    ph_d  = ph_q;
    pl_d  = pl_q;
    opb_d = opb_q;
    if (start_i) begin
      run_d = 1'b1;
      div_d = div_i;
      cnt_d = '0;
      ph_d  = '0;
      pl_d  = a_i;
      opb_d = b_i;
    end else if (run_q) begin
      ph_d  = step_hi;
      pl_d  = step_lo;
      cnt_d = cnt_q + CNT_W'(1);
      if (done_o) begin
        run_d = 1'b0;
        cnt_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      ph_q  <= '0;
      pl_q  <= '0;
      opb_q <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
      pl_q  <= pl_d;
      opb_q <= opb_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage ALU with iterative MULTU/DIVU into HI/LO.
// Define ALU_SEQ_OVERFLOW_EN to add the registered `overflow` output.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Read_data1,
  input  logic [WIDTH-1:0] Read_data2,
  input  logic [3:0]       ALU_Control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUresult,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
`ifdef ALU_SEQ_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept, start, done;
  logic [WIDTH-1:0] eng_hi, eng_lo;
  logic [WIDTH-1:0] sum, diff, alu_res;

  assign accept = in_valid && in_ready;
  assign start  = accept && is_muldiv(ALU_Control);
  assign sum    = Read_data1 + Read_data2;
  assign diff   = Read_data1 - Read_data2;

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .div_i   (ALU_Control == ALU_DIVU),
    .a_i     (Read_data1),
    .b_i     (Read_data2),
    .done_o  (done),
    .hi_o    (eng_hi),
    .lo_o    (eng_lo)
  );

  always_comb begin
    alu_res = '0;
    case (ALU_Control)
      ALU_AND:  alu_res = Read_data1 & Read_data2;
      ALU_OR:   alu_res = Read_data1 | Read_data2;
      ALU_ADD:  alu_res = sum;
      ALU_SUB:  alu_res = diff;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(Read_data1) < $signed(Read_data2)};
      ALU_NOR:  alu_res = ~(Read_data1 | Read_data2);
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  // ---------------- FSM: state register / next state / outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (ALU_Control == ALU_DIVU) ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  end

  // A drained result and a newly accepted single-cycle op may share one edge,
  // which gives back-to-back throughput.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept && !is_muldiv(ALU_Control)) begin
      result_d    = alu_res;
      out_valid_d = 1'b1;
    end
    if (done) begin
      hi_d        = eng_hi;
      lo_d        = eng_lo;
      result_d    = eng_lo;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ALUresult = result_q;
  assign zero      = (result_q == '0);
  assign hi        = hi_q;
  assign lo        = lo_q;

`ifdef ALU_SEQ_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (accept && !is_muldiv(ALU_Control)) begin
      case (ALU_Control)
        ALU_ADD: ovf_d = (Read_data1[WIDTH-1] == Read_data2[WIDTH-1]) &&
                         (sum[WIDTH-1] != Read_data1[WIDTH-1]);
        ALU_SUB: ovf_d = (Read_data1[WIDTH-1] != Read_data2[WIDTH-1]) &&
                         (diff[WIDTH-1] != Read_data1[WIDTH-1]);
        default: ovf_d = 1'b0;
      endcase
    end
    if (done) ovf_d = (state_q == ST_MUL) && (eng_hi != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

`ifndef SYNTHESIS
  a_hilo_stable : assert property (@(posedge clk) disable iff (rst)
    (busy && !done) |=> ($stable(hi_q) && $stable(lo_q)));
  a_out_hold : assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !out_ready) |=> (out_valid_q && $stable(result_q)));
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq against a
// behavioural model using plain arithmetic on HI/LO state.
module tb_alu_seq;

  localparam int W = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] Read_data1 = '0;
  logic [W-1:0] Read_data2 = '0;
  logic [3:0]   ALU_Control = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] ALUresult;
  logic         zero;
  logic [W-1:0] hi, lo;
  logic         busy;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic         overflow;
`endif

  int errors = 0;
  int checks = 0;

  // Model of the architectural HI/LO registers.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Read_data1  (Read_data1),
    .Read_data2  (Read_data2),
    .ALU_Control (ALU_Control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUresult   (ALUresult),
    .zero        (zero),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy)
`ifdef ALU_SEQ_OVERFLOW_EN
    ,
    .overflow    (overflow)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_single(input logic [3:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return W'(64'(a) + 64'(b));
      OP_SUB:  return W'(64'(a) - 64'(b));
      OP_SLT:  return (sa < sb) ? W'(1) : W'(0);
      OP_NOR:  return ~(a | b);
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return '0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || ALUresult !== '0 || hi !== '0 || lo !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b ALUresult=%h hi=%h lo=%h busy=%b, required all zero",
               out_valid, ALUresult, hi, lo, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_add_overflow();
    Read_data1 = 32'h7FFF_FFFF; Read_data2 = 32'h1; ALU_Control = OP_ADD;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ALUresult !== 32'h8000_0000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf: out_valid=%b ALUresult=%h zero=%b required 1 80000000 0",
               out_valid, ALUresult, zero);
    end
`ifdef ALU_SEQ_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL add_ovf_flag: got %b required 1", overflow);
    end
`endif
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic do_single(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp;
    exp = ref_single(op, a, b);
    Read_data1 = a; Read_data2 = b; ALU_Control = op; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ALUresult !== exp || zero !== (exp == '0)) begin
      errors++;
      $display("FAIL single op=%b a=%h b=%h: out_valid=%b ALUresult=%h zero=%b required 1 %h %b",
               op, a, b, out_valid, ALUresult, zero, exp, (exp == '0));
    end
    tick();
  endtask

  task automatic test_directed_single();
    do_single(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    do_single(OP_SLT, 32'h1, 32'hFFFF_FFFF);
    do_single(OP_SUB, 32'd5, 32'd5);
    do_single(OP_NOR, 32'h0F0F_0000, 32'h00F0_F0F0);
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops [10] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR,
                               OP_MFHI, OP_MFLO, 4'b0011, 4'b1111};
    logic [W-1:0] a, b, exp;
    logic [3:0]   op;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 9)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 3));
      exp = ref_single(op, a, b);
      Read_data1 = a; Read_data2 = b; ALU_Control = op; in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || ALUresult !== exp || zero !== (exp == '0)) begin
        errors++;
        $display("FAIL b2b[%0d] op=%b a=%h b=%h: out_valid=%b ALUresult=%h zero=%b required 1 %h %b",
                 i, op, a, b, out_valid, ALUresult, zero, exp, (exp == '0));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic do_multi(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    logic [W-1:0]   eh, el, prev_hi, prev_lo;
    prev_hi = m_hi;
    prev_lo = m_lo;
    if (op == OP_MULTU) begin
      prod = 64'(a) * 64'(b);
      eh   = prod[2*W-1:W];
      el   = prod[W-1:0];
    end else if (b == '0) begin
      eh = a;
      el = '1;
    end else begin
      eh = a % b;
      el = a / b;
    end
    Read_data1 = a; Read_data2 = b; ALU_Control = op; in_valid = 1'b1; out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL multi_ready op=%b: in_ready=%b required 1", op, in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      Read_data1 = $urandom; Read_data2 = $urandom; ALU_Control = 4'($urandom);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || hi !== prev_hi || lo !== prev_lo) begin
        errors++;
        $display("FAIL multi_busy op=%b cycle %0d: busy=%b in_ready=%b out_valid=%b hi=%h lo=%h required 1 0 0 %h %h",
                 op, i, busy, in_ready, out_valid, hi, lo, prev_hi, prev_lo);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || ALUresult !== el || hi !== eh || lo !== el || zero !== (el == '0)) begin
      errors++;
      $display("FAIL multi_done op=%b a=%h b=%h: out_valid=%b busy=%b ALUresult=%h hi=%h lo=%h required 1 0 %h %h %h",
               op, a, b, out_valid, busy, ALUresult, hi, lo, el, eh, el);
    end
`ifdef ALU_SEQ_OVERFLOW_EN
    checks++;
    if (overflow !== (op == OP_MULTU && eh != '0)) begin
      errors++;
      $display("FAIL multi_ovf op=%b: got %b required %b", op, overflow, (op == OP_MULTU && eh != '0));
    end
`endif
    m_hi = eh;
    m_lo = el;
    tick();
  endtask

  task automatic test_muldiv();
    logic [W-1:0] a, b;
    do_multi(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    do_multi(OP_DIVU, 32'd100, 32'd7);
    do_single(OP_MFLO, 32'h0, 32'h0);
    do_multi(OP_DIVU, 32'd9, 32'd0);
    do_single(OP_MFHI, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? '0 : (($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 300)) : $urandom);
      do_multi(($urandom_range(0, 1) == 0) ? OP_MULTU : OP_DIVU, a, b);
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] a, b, a2, b2, exp;
    a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
    exp = a & b;
    Read_data1 = a; Read_data2 = b; ALU_Control = OP_AND; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    Read_data1 = a2; Read_data2 = b2; ALU_Control = OP_OR;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || ALUresult !== exp || zero !== (exp == '0) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: out_valid=%b ALUresult=%h in_ready=%b required 1 %h 0",
                 i, out_valid, ALUresult, in_ready, exp);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ALUresult !== (a2 | b2)) begin
      errors++;
      $display("FAIL hold_pending: out_valid=%b ALUresult=%h required 1 %h", out_valid, ALUresult, a2 | b2);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen;
    Read_data1 = $urandom | 32'h8000_0000; Read_data2 = $urandom | 32'h1;
    ALU_Control = OP_MULTU; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || hi !== '0 || lo !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset: out_valid=%b hi=%h lo=%h busy=%b required 0 0 0 0", out_valid, hi, lo, busy);
    end
    tick();
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_result: stray out_valid/busy seen=%b required 0", seen);
    end
    do_single(OP_ADD, $urandom, $urandom);
    do_single(OP_MFHI, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_directed_single();
    test_back_to_back();
    test_muldiv();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
